// File: rtl/unit1_rs_pkg.sv
// Shared types and constants for the unit1 reservation station.
// Holds the entry record, the issue record, opcode constants and the
// operand wakeup helper used by both existing entries and dispatch.
package unit1_rs_pkg;

  // Tag width the entry records are built for; tag 0 = no register.
  localparam int TAGW = 6;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BR   = 6'b000100;
  localparam logic [5:0] OP_JR   = 6'b000110;
  localparam logic [5:0] OP_JALR = 6'b000111;

  typedef struct packed {
    logic            valid;
    logic [13:0]     pc;
    logic [5:0]      ope;
    logic [15:0]     imm;
    logic [4:0]      opr;
    logic [3:0]      ctrl;
    logic [TAGW-1:0] dd;
    logic [TAGW-1:0] ds_tag;
    logic [TAGW-1:0] dt_tag;
    logic [31:0]     ds_val;
    logic [31:0]     dt_val;
    logic            ds_rdy;
    logic            dt_rdy;
  } rs_entry_t;

  typedef struct packed {
    logic [13:0]     pc;
    logic [5:0]      ope;
    logic [31:0]     ds_val;
    logic [31:0]     dt_val;
    logic [TAGW-1:0] dd;
    logic [15:0]     imm;
    logic [4:0]      opr;
    logic [3:0]      ctrl;
  } rs_issue_t;

  typedef struct packed {
    logic        rdy;
    logic [31:0] val;
  } src_t;

  // A waiting source with a nonzero tag snoops both result buses; wb0 wins.
  function automatic src_t wake_src(input logic rdy, input logic [TAGW-1:0] tag,
                                    input logic [31:0] val,
                                    input logic [TAGW-1:0] t0, input logic [31:0] v0,
                                    input logic [TAGW-1:0] t1, input logic [31:0] v1);
    src_t s;
    s.rdy = rdy;
    s.val = val;
    if (!rdy && tag != '0) begin
      if (tag == t0) begin
        s.rdy = 1'b1;
        s.val = v0;
      end else if (tag == t1) begin
        s.rdy = 1'b1;
        s.val = v1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/unit1_rs_if.sv
// Dispatch channel into the reservation station.
// Handshake: a dispatch is accepted on a rising edge where in_valid and
// in_ready are both high; in_ready is high whenever a free entry exists and
// does not look at same-cycle issue. Fields must be stable while in_valid.
interface unit1_rs_if #(parameter int TAGW = 6);
  logic            in_valid;
  logic            in_ready;
  logic [13:0]     in_pc;
  logic [5:0]      in_ope;
  logic [15:0]     in_imm;
  logic [4:0]      in_opr;
  logic [3:0]      in_ctrl;
  logic [TAGW-1:0] in_dd;
  logic [TAGW-1:0] in_ds_tag;
  logic [TAGW-1:0] in_dt_tag;
  logic [31:0]     in_ds_val;
  logic [31:0]     in_dt_val;
  logic            in_ds_rdy;
  logic            in_dt_rdy;

  modport master (
    output in_valid, in_pc, in_ope, in_imm, in_opr, in_ctrl, in_dd,
           in_ds_tag, in_dt_tag, in_ds_val, in_dt_val, in_ds_rdy, in_dt_rdy,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_ope, in_imm, in_opr, in_ctrl, in_dd,
           in_ds_tag, in_dt_tag, in_ds_val, in_dt_val, in_ds_rdy, in_dt_rdy,
    output in_ready
  );
endinterface

// File: rtl/unit1_rs_select.sv
// Oldest-eligible pick: slot 0 is oldest, so the lowest set bit wins.
module rs_select #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 2
) (
  input  logic [DEPTH-1:0] elig,
  output logic             found,
  output logic [IDXW-1:0]  idx
);

  // Scan youngest to oldest so the last hit is the oldest eligible slot.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        idx   = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/unit1_rs.sv
// unit1_rs: age-ordered reservation station with registered issue.
// Optional macro WAKEUP_BYPASS_EN: a source woken by a broadcast becomes
// eligible in the same cycle, its broadcast value going straight into the
// issue register. Without it, wakeups are seen by the selector one cycle later.
// Entry records use unit1_rs_pkg::TAGW; keep the TAGW parameter equal to it.
module unit1_rs
  import unit1_rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = unit1_rs_pkg::TAGW
) (
  input  logic            clk,
  input  logic            rst,
  unit1_rs_if.slave       disp,
  input  logic [TAGW-1:0] wb0_tag,
  input  logic [31:0]     wb0_val,
  input  logic [TAGW-1:0] wb1_tag,
  input  logic [31:0]     wb1_val,
  input  logic            flush,
  input  logic [6:0]      ex_busy,
  output logic [13:0]     pc,
  output logic [5:0]      ope,
  output logic [31:0]     ds_val,
  output logic [31:0]     dt_val,
  output logic [TAGW-1:0] dd,
  output logic [15:0]     imm,
  output logic [4:0]      opr,
  output logic [3:0]      ctrl,
  output logic [3:0]      count
);

  localparam int IDXW = $clog2(DEPTH);

  rs_entry_t       ent_q [DEPTH];
  rs_entry_t       ent_w [DEPTH+1];  // after wakeup; extra slot is an empty filler for compaction
  rs_entry_t       ent_n [DEPTH];
  rs_entry_t       new_ent;
  rs_issue_t       iss_q, iss_n;
  logic [3:0]      count_q, count_n, wr_idx;
  logic [DEPTH-1:0] elig;
  logic            sel_found, issue_fire, acc;
  logic [IDXW-1:0] sel_idx;
  src_t            s_ds, s_dt;

  assign disp.in_ready = (count_q < 4'(DEPTH));
  assign acc           = disp.in_valid && disp.in_ready;
  assign issue_fire    = sel_found && (ex_busy == '0) && !flush;
  assign wr_idx        = count_q - {3'b000, issue_fire};
  assign count_n       = count_q + {3'b000, acc} - {3'b000, issue_fire};

  // Broadcast capture for every stored entry, plus eligibility.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s_ds = wake_src(ent_q[i].ds_rdy, ent_q[i].ds_tag, ent_q[i].ds_val,
                      wb0_tag, wb0_val, wb1_tag, wb1_val);
      s_dt = wake_src(ent_q[i].dt_rdy, ent_q[i].dt_tag, ent_q[i].dt_val,
                      wb0_tag, wb0_val, wb1_tag, wb1_val);
      ent_w[i]        = ent_q[i];
      ent_w[i].ds_rdy = s_ds.rdy;
      ent_w[i].ds_val = s_ds.val;
      ent_w[i].dt_rdy = s_dt.rdy;
      ent_w[i].dt_val = s_dt.val;
`ifdef WAKEUP_BYPASS_EN
      elig[i] = ent_w[i].valid && ent_w[i].ds_rdy && ent_w[i].dt_rdy;
`else
      elig[i] = ent_q[i].valid && ent_q[i].ds_rdy && ent_q[i].dt_rdy;
`endif
    end
    ent_w[DEPTH] = '0;
  end

  rs_select #(.DEPTH(DEPTH), .IDXW(IDXW)) u_select (
    .elig  (elig),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Incoming entry, with tag 0 treated as ready and dispatch-time wakeup.
  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.pc     = disp.in_pc;
    new_ent.ope    = disp.in_ope;
    new_ent.imm    = disp.in_imm;
    new_ent.opr    = disp.in_opr;
    new_ent.ctrl   = disp.in_ctrl;
    new_ent.dd     = disp.in_dd;
    new_ent.ds_tag = disp.in_ds_tag;
    new_ent.dt_tag = disp.in_dt_tag;
    s_ds_new_blk : begin end
    new_ent.ds_rdy = wake_src(disp.in_ds_rdy || (disp.in_ds_tag == '0), disp.in_ds_tag,
                              disp.in_ds_val, wb0_tag, wb0_val, wb1_tag, wb1_val).rdy;
    new_ent.ds_val = wake_src(disp.in_ds_rdy || (disp.in_ds_tag == '0), disp.in_ds_tag,
                              disp.in_ds_val, wb0_tag, wb0_val, wb1_tag, wb1_val).val;
    new_ent.dt_rdy = wake_src(disp.in_dt_rdy || (disp.in_dt_tag == '0), disp.in_dt_tag,
                              disp.in_dt_val, wb0_tag, wb0_val, wb1_tag, wb1_val).rdy;
    new_ent.dt_val = wake_src(disp.in_dt_rdy || (disp.in_dt_tag == '0), disp.in_dt_tag,
                              disp.in_dt_val, wb0_tag, wb0_val, wb1_tag, wb1_val).val;
  end

  // Remove the issued slot by shifting younger entries down, then append.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (i >= int'(sel_idx))) ent_n[i] = ent_w[i+1];
      else                                    ent_n[i] = ent_w[i];
      if (acc && (i == int'(wr_idx)))         ent_n[i] = new_ent;
    end
  end

  // Issue payload from the selected (already woken) entry, else a no-op.
  always_comb begin
    iss_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (IDXW'(i) == sel_idx)) begin
        iss_n.pc     = ent_w[i].pc;
        iss_n.ope    = ent_w[i].ope;
        iss_n.ds_val = ent_w[i].ds_val;
        iss_n.dt_val = ent_w[i].dt_val;
        iss_n.dd     = ent_w[i].dd;
        iss_n.imm    = ent_w[i].imm;
        iss_n.opr    = ent_w[i].opr;
        iss_n.ctrl   = ent_w[i].ctrl;
      end
    end
  end

  // State update; reset and flush both empty the station and emit a no-op.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      iss_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
      count_q <= count_n;
      iss_q   <= iss_n;
    end
  end

  assign pc     = iss_q.pc;
  assign ope    = iss_q.ope;
  assign ds_val = iss_q.ds_val;
  assign dt_val = iss_q.dt_val;
  assign dd     = iss_q.dd;
  assign imm    = iss_q.imm;
  assign opr    = iss_q.opr;
  assign ctrl   = iss_q.ctrl;
  assign count  = count_q;

endmodule

// File: tb/tb_unit1_rs.sv
// Bench for unit1_rs: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_unit1_rs;

  localparam int DEPTH = 4;
`ifdef WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]  wb0_tag, wb1_tag;
  logic [31:0] wb0_val, wb1_val;
  logic        flush;
  logic [6:0]  ex_busy;
  logic [13:0] pc;
  logic [5:0]  ope;
  logic [31:0] ds_val, dt_val;
  logic [5:0]  dd;
  logic [15:0] imm;
  logic [4:0]  opr;
  logic [3:0]  ctrl;
  logic [3:0]  count;

  unit1_rs_if #(.TAGW(6)) disp_if ();

  unit1_rs #(.DEPTH(DEPTH), .TAGW(6)) dut (
    .clk(clk), .rst(rst), .disp(disp_if),
    .wb0_tag(wb0_tag), .wb0_val(wb0_val), .wb1_tag(wb1_tag), .wb1_val(wb1_val),
    .flush(flush), .ex_busy(ex_busy),
    .pc(pc), .ope(ope), .ds_val(ds_val), .dt_val(dt_val), .dd(dd),
    .imm(imm), .opr(opr), .ctrl(ctrl), .count(count)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [13:0] pc;
    logic [5:0]  ope;
    logic [15:0] imm;
    logic [4:0]  opr;
    logic [3:0]  ctrl;
    logic [5:0]  dd;
    logic [5:0]  ds_tag, dt_tag;
    logic [31:0] ds_val, dt_val;
    bit          ds_rdy, dt_rdy;
  } m_ent_t;

  m_ent_t         m_q[$];   // waiting instructions, oldest first
  logic [114:0]   exp_q[$]; // expected issue bundle after each edge

  function automatic m_ent_t snoop(input m_ent_t e);
    m_ent_t r = e;
    if (!r.ds_rdy) begin
      if (r.ds_tag == wb0_tag)      begin r.ds_rdy = 1; r.ds_val = wb0_val; end
      else if (r.ds_tag == wb1_tag) begin r.ds_rdy = 1; r.ds_val = wb1_val; end
    end
    if (!r.dt_rdy) begin
      if (r.dt_tag == wb0_tag)      begin r.dt_rdy = 1; r.dt_val = wb0_val; end
      else if (r.dt_tag == wb1_tag) begin r.dt_rdy = 1; r.dt_val = wb1_val; end
    end
    return r;
  endfunction

  // One clock edge of the reference: wake, pick oldest ready, remove, append.
  task automatic model_step();
    m_ent_t       w[$];
    m_ent_t       e;
    logic [114:0] o;
    int           sel;
    bit           acc;
    o   = '0;
    sel = -1;
    if (rst || flush) begin
      m_q.delete();
    end else begin
      acc = disp_if.in_valid && (m_q.size() < DEPTH);
      w = m_q;
      foreach (w[k]) w[k] = snoop(w[k]);
      if (ex_busy == 7'd0) begin
        foreach (m_q[k]) begin
          if (sel < 0 && (BYPASS ? (w[k].ds_rdy && w[k].dt_rdy)
                                 : (m_q[k].ds_rdy && m_q[k].dt_rdy)))
            sel = k;
        end
      end
      m_q = w;
      if (sel >= 0) begin
        e = m_q[sel];
        o = {e.pc, e.ope, e.ds_val, e.dt_val, e.dd, e.imm, e.opr, e.ctrl};
        m_q.delete(sel);
      end
      if (acc) begin
        e.pc = disp_if.in_pc;  e.ope = disp_if.in_ope; e.imm = disp_if.in_imm;
        e.opr = disp_if.in_opr; e.ctrl = disp_if.in_ctrl; e.dd = disp_if.in_dd;
        e.ds_tag = disp_if.in_ds_tag; e.dt_tag = disp_if.in_dt_tag;
        e.ds_val = disp_if.in_ds_val; e.dt_val = disp_if.in_dt_val;
        e.ds_rdy = disp_if.in_ds_rdy || (disp_if.in_ds_tag == 6'd0);
        e.dt_rdy = disp_if.in_dt_rdy || (disp_if.in_dt_tag == 6'd0);
        m_q.push_back(snoop(e));
      end
    end
    exp_q.push_back(o);
  endtask

  task automatic tick();
    logic [114:0] o;
    @(posedge clk);
    model_step();
    #1;
    o = exp_q.pop_front();
    check("issue", {pc, ope, ds_val, dt_val, dd, imm, opr, ctrl}, o);
    check("count", count, m_q.size());
    check("in_ready", disp_if.in_ready, (m_q.size() < DEPTH));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    disp_if.in_valid = 0; disp_if.in_pc = '0; disp_if.in_ope = '0; disp_if.in_imm = '0;
    disp_if.in_opr = '0; disp_if.in_ctrl = '0; disp_if.in_dd = '0;
    disp_if.in_ds_tag = '0; disp_if.in_dt_tag = '0; disp_if.in_ds_val = '0;
    disp_if.in_dt_val = '0; disp_if.in_ds_rdy = 0; disp_if.in_dt_rdy = 0;
    wb0_tag = '0; wb0_val = '0; wb1_tag = '0; wb1_val = '0;
    flush = 0; ex_busy = '0;
  endtask

  task automatic dispatch(input logic [13:0] p, input logic [5:0] op,
                          input logic [5:0] st, input logic [31:0] sv, input bit sr,
                          input logic [5:0] tt, input logic [31:0] tv, input bit tr);
    disp_if.in_valid = 1; disp_if.in_pc = p; disp_if.in_ope = op;
    disp_if.in_imm = 16'(p * 3); disp_if.in_opr = 5'(p); disp_if.in_ctrl = 4'(op);
    disp_if.in_dd = 6'(p + 1);
    disp_if.in_ds_tag = st; disp_if.in_ds_val = sv; disp_if.in_ds_rdy = sr;
    disp_if.in_dt_tag = tt; disp_if.in_dt_val = tv; disp_if.in_dt_rdy = tr;
  endtask

  task automatic drive_rand();
    disp_if.in_valid  = ($urandom_range(0, 2) != 0);
    disp_if.in_pc     = 14'($urandom);
    disp_if.in_ope    = 6'($urandom_range(1, 63));
    disp_if.in_imm    = 16'($urandom);
    disp_if.in_opr    = 5'($urandom);
    disp_if.in_ctrl   = 4'($urandom);
    disp_if.in_dd     = 6'($urandom);
    disp_if.in_ds_tag = 6'($urandom_range(0, 7));
    disp_if.in_dt_tag = 6'($urandom_range(0, 7));
    disp_if.in_ds_val = $urandom;
    disp_if.in_dt_val = $urandom;
    disp_if.in_ds_rdy = ($urandom_range(0, 2) == 0);
    disp_if.in_dt_rdy = ($urandom_range(0, 2) == 0);
    wb0_tag = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 7)) : 6'd0;
    wb1_tag = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 7)) : 6'd0;
    wb0_val = $urandom;
    wb1_val = $urandom;
    flush   = ($urandom_range(0, 39) == 0);
    ex_busy = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1;
    drive_idle();
    tick();
    tick();
    check("rst_count", count, 4'd0);
    check("rst_ope", ope, 6'b000000);
    check("rst_ready", disp_if.in_ready, 1'b1);
    rst = 0;

    // ADD with both sources ready: visible two edges after dispatch
    dispatch(14'h0100, 6'b001100, 6'd0, 32'd5, 1, 6'd0, 32'd7, 1);
    tick();
    drive_idle();
    tick();
    check("add_ope", ope, 6'b001100);
    check("add_ds", ds_val, 32'd5);
    check("add_dt", dt_val, 32'd7);
    check("add_count", count, 4'd0);

    // ADDI waiting on tag 3, woken by wb1 three cycles after dispatch
    dispatch(14'h0200, 6'b001101, 6'd3, 32'd0, 0, 6'd0, 32'd9, 1);
    tick();
    drive_idle();
    tick();
    tick();
    wb1_tag = 6'd3; wb1_val = 32'h10;
    tick();
    drive_idle();
    if (!BYPASS) tick();
    check("wake_ope", ope, 6'b001101);
    check("wake_ds", ds_val, 32'h10);
    tick();

    // fill with unready entries, refuse a fifth, wake slot 2
    for (int k = 0; k < 4; k++) begin
      dispatch(14'(16'h300 + k), 6'(8 + k), 6'(10 + k), 32'd0, 0, 6'd0, 32'd1, 1);
      tick();
    end
    check("full_count", count, 4'd4);
    check("full_ready", disp_if.in_ready, 1'b0);
    dispatch(14'h03ff, 6'd20, 6'd0, 32'd2, 1, 6'd0, 32'd3, 1);
    tick();
    drive_idle();
    wb0_tag = 6'd12; wb0_val = 32'hAB;
    tick();
    drive_idle();
    if (!BYPASS) tick();
    check("slot2_pc", pc, 14'h302);
    check("slot2_ready", disp_if.in_ready, 1'b1);

    // three pending, flush alongside a ready dispatch
    dispatch(14'h0400, 6'd21, 6'd0, 32'd4, 1, 6'd0, 32'd4, 1);
    flush = 1;
    tick();
    check("flush_count", count, 4'd0);
    check("flush_ope", ope, 6'b000000);
    drive_idle();
    for (int k = 0; k < 3; k++) tick();

    // two ready entries held by ex_busy for three cycles, then oldest first
    ex_busy = 7'b0000001;
    dispatch(14'h0500, 6'd22, 6'd0, 32'd1, 1, 6'd0, 32'd1, 1);
    tick();
    dispatch(14'h0501, 6'd23, 6'd0, 32'd2, 1, 6'd0, 32'd2, 1);
    tick();
    disp_if.in_valid = 0;
    tick();
    check("busy_hold_ope", ope, 6'b000000);
    ex_busy = '0;
    tick();
    check("older_pc", pc, 14'h0500);
    tick();
    check("younger_pc", pc, 14'h0501);

    // randomized traffic with one mid-run reset
    for (int n = 0; n < 400; n++) begin
      drive_rand();
      rst = (n == 200);
      tick();
    end
    rst = 0;
    drive_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
